// File: rtl/minbd_side_buffer_if.sv
// Flit type shared by the MinBD side-buffer and its bus interface.
// The interface bundles the permutation-network inputs, output links and re-injection port.
package minbd_sb_pkg;

  typedef struct packed {
    logic        vld;
    logic        golden;
    logic        silver;
    logic        deflect;
    logic [3:0]  dst;
    logic [23:0] payload;
  } flit_int_t;

endpackage

interface minbd_sb_if #(
  parameter int SB_DEPTH = 4
);
  import minbd_sb_pkg::*;

  localparam int CNT_W = $clog2(SB_DEPTH) + 1;

  flit_int_t        pn_in_0;
  flit_int_t        pn_in_1;
  flit_int_t        pn_in_2;
  flit_int_t        pn_in_3;
  flit_int_t        link_out_0;
  flit_int_t        link_out_1;
  flit_int_t        link_out_2;
  flit_int_t        link_out_3;
  flit_int_t        sb_out;
  logic             sb_out_vld;
  logic             sb_out_rdy;
  logic             sb_redirect_req;
  logic [CNT_W-1:0] sb_count;
  logic [15:0]      sb_stat_buffered;
  logic [15:0]      sb_stat_redirect;

  // Router side: drives the permuted flits and the re-injection ready.
  modport master (
    output pn_in_0, pn_in_1, pn_in_2, pn_in_3, sb_out_rdy,
    input  link_out_0, link_out_1, link_out_2, link_out_3,
    input  sb_out, sb_out_vld, sb_redirect_req, sb_count,
    input  sb_stat_buffered, sb_stat_redirect
  );

  modport slave (
    input  pn_in_0, pn_in_1, pn_in_2, pn_in_3, sb_out_rdy,
    output link_out_0, link_out_1, link_out_2, link_out_3,
    output sb_out, sb_out_vld, sb_redirect_req, sb_count,
    output sb_stat_buffered, sb_stat_redirect
  );

endinterface

// File: rtl/minbd_side_buffer.sv
// MinBD side-buffer: registers permuted flits onto the links and pulls one deflected flit per cycle into a FIFO.
// Optional statistics counters are enabled with `define MINBD_SB_STATS_EN.
module minbd_side_buffer
  import minbd_sb_pkg::*;
#(
  parameter int SB_DEPTH     = 4,
  parameter int REDIR_THRESH = 2
) (
  input logic       clk,
  input logic       rst_n,
  minbd_sb_if.slave bus
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_WAIT,
    ST_REDIRECT
  } sb_state_e;

  flit_int_t        w_pn     [4];
  flit_int_t        w_link_d [4];
  flit_int_t        r_link   [4];
  flit_int_t        r_mem    [SB_DEPTH];
  flit_int_t        w_wr_flit;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_cand_vld;
  logic [1:0]       w_cand_idx;
  logic             w_head_vld;
  logic             w_pop;
  logic             w_push;
  logic             w_stalled;
  logic             w_empties;

  sb_state_e        r_state;
  sb_state_e        w_state_nxt;
  logic [3:0]       r_stall;
  logic [3:0]       w_stall_nxt;
  logic [3:0]       w_stall_inc;
  logic             r_redirect_req;

  assign w_pn[0] = bus.pn_in_0;
  assign w_pn[1] = bus.pn_in_1;
  assign w_pn[2] = bus.pn_in_2;
  assign w_pn[3] = bus.pn_in_3;

  // Lowest-index deflected non-golden flit wins; scanning downward lets the lowest overwrite.
  always_comb begin
    w_cand_vld = 1'b0;
    w_cand_idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (w_pn[i].vld && w_pn[i].deflect && !w_pn[i].golden) begin
        w_cand_vld = 1'b1;
        w_cand_idx = 2'(i);
      end
    end
  end

  assign w_head_vld = (r_count != '0);
  assign w_pop      = w_head_vld && bus.sb_out_rdy;
  assign w_push     = w_cand_vld && ((r_count < CNT_W'(SB_DEPTH)) || w_pop);

  always_comb begin
    w_wr_flit         = w_pn[w_cand_idx];
    w_wr_flit.deflect = 1'b0;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_link_d[i] = w_pn[i];
      if (w_push && (w_cand_idx == 2'(i))) begin
        w_link_d[i].vld = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        r_link[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_link[i] <= w_link_d[i];
      end
    end
  end

  assign bus.link_out_0 = r_link[0];
  assign bus.link_out_1 = r_link[1];
  assign bus.link_out_2 = r_link[2];
  assign bus.link_out_3 = r_link[3];

  // NOTE: storage has no reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_flit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.sb_out     = r_mem[r_rd_ptr];
  assign bus.sb_out_vld = w_head_vld;
  assign bus.sb_count   = r_count;

  assign w_stalled   = w_head_vld && !bus.sb_out_rdy;
  assign w_empties   = w_pop && !w_push && (r_count == CNT_W'(1));
  assign w_stall_inc = (r_stall == 4'hF) ? r_stall : r_stall + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_EMPTY;
      r_stall        <= '0;
      r_redirect_req <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_stall        <= w_stall_nxt;
      r_redirect_req <= (w_state_nxt == ST_REDIRECT);
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_stall_nxt = r_stall;
    case (r_state)
      ST_EMPTY: begin
        if (w_push) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_pop) begin
          w_stall_nxt = '0;
          if (w_empties) begin
            w_state_nxt = ST_EMPTY;
          end
        end else if (w_stalled) begin
          w_stall_nxt = w_stall_inc;
          if (w_stall_inc >= 4'(REDIR_THRESH)) begin
            w_state_nxt = ST_REDIRECT;
          end
        end
      end
      ST_REDIRECT: begin
        if (w_pop) begin
          w_stall_nxt = '0;
          w_state_nxt = w_empties ? ST_EMPTY : ST_WAIT;
        end else if (w_stalled) begin
          w_stall_nxt = w_stall_inc;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
        w_stall_nxt = '0;
      end
    endcase
  end

  assign bus.sb_redirect_req = r_redirect_req;

`ifdef MINBD_SB_STATS_EN
  logic [15:0] r_stat_buffered;
  logic [15:0] r_stat_redirect;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_buffered <= '0;
      r_stat_redirect <= '0;
    end else begin
      if (w_push && (r_stat_buffered != 16'hFFFF)) begin
        r_stat_buffered <= r_stat_buffered + 16'd1;
      end
      if ((r_state == ST_WAIT) && (w_state_nxt == ST_REDIRECT) &&
          (r_stat_redirect != 16'hFFFF)) begin
        r_stat_redirect <= r_stat_redirect + 16'd1;
      end
    end
  end

  assign bus.sb_stat_buffered = r_stat_buffered;
  assign bus.sb_stat_redirect = r_stat_redirect;
`else
  assign bus.sb_stat_buffered = '0;
  assign bus.sb_stat_redirect = '0;
`endif

endmodule

// File: tb/tb_minbd_side_buffer.sv
// Scoreboard bench for minbd_side_buffer: a queue holds the flits expected in the side buffer,
// checked at every pop and against the head each cycle; links, count and redirect are modelled per cycle.
module tb_minbd_side_buffer;
  import minbd_sb_pkg::*;

  localparam int DEPTH  = 4;
  localparam int THRESH = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  minbd_sb_if #(.SB_DEPTH(DEPTH)) bus ();

  minbd_side_buffer #(
    .SB_DEPTH    (DEPTH),
    .REDIR_THRESH(THRESH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int        checks = 0;
  int        errors = 0;
  flit_int_t stim [4];
  logic      rdy;
  flit_int_t sb_q [$];
  int        stall_m;
  logic      req_m;
  int        pushes_m;
  int        redirs_m;

  function automatic flit_int_t mk(logic golden, logic silver, logic deflect, logic [23:0] pl);
    flit_int_t f;
    f         = '0;
    f.vld     = 1'b1;
    f.golden  = golden;
    f.silver  = silver;
    f.deflect = deflect;
    f.dst     = pl[3:0];
    f.payload = pl;
    return f;
  endfunction

  function automatic flit_int_t rnd_flit();
    flit_int_t f;
    f.vld     = ($urandom_range(0, 9) < 7);
    f.golden  = ($urandom_range(0, 4) == 0);
    f.silver  = 1'($urandom_range(0, 1));
    f.deflect = 1'($urandom_range(0, 1));
    f.dst     = 4'($urandom);
    f.payload = 24'($urandom);
    return f;
  endfunction

  function automatic flit_int_t link_of(int i);
    case (i)
      0:       return bus.link_out_0;
      1:       return bus.link_out_1;
      2:       return bus.link_out_2;
      default: return bus.link_out_3;
    endcase
  endfunction

  task automatic apply_inputs();
    bus.pn_in_0    = stim[0];
    bus.pn_in_1    = stim[1];
    bus.pn_in_2    = stim[2];
    bus.pn_in_3    = stim[3];
    bus.sb_out_rdy = rdy;
  endtask

  task automatic set_idle();
    for (int i = 0; i < 4; i++) stim[i] = '0;
    rdy = 1'b0;
  endtask

  task automatic clear_model();
    sb_q.delete();
    stall_m  = 0;
    req_m    = 1'b0;
    pushes_m = 0;
    redirs_m = 0;
  endtask

  // Called just after a rising edge; applies stim/rdy, updates the model, checks after the next edge.
  task automatic step();
    int        cand;
    int        size_before;
    bit        exp_pop;
    bit        exp_push;
    logic      prev_req;
    flit_int_t f;
    flit_int_t exp_link [4];
    apply_inputs();
    cand = -1;
    for (int i = 0; i < 4; i++)
      if (cand < 0 && stim[i].vld && stim[i].deflect && !stim[i].golden) cand = i;
    size_before = sb_q.size();
    exp_pop     = (size_before > 0) && rdy;
    exp_push    = (cand >= 0) && ((size_before < DEPTH) || exp_pop);
    for (int i = 0; i < 4; i++) exp_link[i] = stim[i];
    #1;
    if (exp_pop) begin
      checks++;
      if (bus.sb_out !== sb_q[0]) begin
        errors++;
        $display("FAIL pop_data got %h want %h", bus.sb_out, sb_q[0]);
      end
      void'(sb_q.pop_front());
    end
    if (exp_push) begin
      f         = stim[cand];
      f.deflect = 1'b0;
      sb_q.push_back(f);
      pushes_m++;
      exp_link[cand].vld = 1'b0;
    end
    if (exp_pop) stall_m = 0;
    else if (size_before > 0 && !rdy && stall_m < 15) stall_m++;
    prev_req = req_m;
    req_m    = (stall_m >= THRESH);
    if (!prev_req && req_m) redirs_m++;

    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (exp_push && cand == i) begin
        if (link_of(i).vld !== 1'b0) begin
          errors++;
          $display("FAIL link%0d_captured_vld got %b want 0", i, link_of(i).vld);
        end
      end else if (link_of(i) !== exp_link[i]) begin
        errors++;
        $display("FAIL link%0d got %h want %h", i, link_of(i), exp_link[i]);
      end
    end
    checks++;
    if (int'(bus.sb_count) != sb_q.size()) begin
      errors++;
      $display("FAIL count got %0d want %0d", bus.sb_count, sb_q.size());
    end
    checks++;
    if (bus.sb_out_vld !== (sb_q.size() > 0)) begin
      errors++;
      $display("FAIL out_vld got %b want %b", bus.sb_out_vld, (sb_q.size() > 0));
    end
    if (sb_q.size() > 0) begin
      checks++;
      if (bus.sb_out !== sb_q[0]) begin
        errors++;
        $display("FAIL head got %h want %h", bus.sb_out, sb_q[0]);
      end
    end
    checks++;
    if (bus.sb_redirect_req !== req_m) begin
      errors++;
      $display("FAIL redirect_req got %b want %b", bus.sb_redirect_req, req_m);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) stim[i] = mk(1'b0, 1'b0, 1'b1, 24'(32'hA0 + i));
    rdy = 1'b1;
    apply_inputs();
    repeat (2) @(posedge clk);
    #1;
    clear_model();
    rst_n = 1'b1;
    set_idle();
    apply_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.link_out_0 !== '0 || bus.link_out_1.vld !== 1'b0 ||
        bus.link_out_2.vld !== 1'b0 || bus.link_out_3.vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_links got %h %b %b %b want 0 0 0 0", bus.link_out_0,
               bus.link_out_1.vld, bus.link_out_2.vld, bus.link_out_3.vld);
    end
    checks++;
    if (bus.sb_count !== '0 || bus.sb_out_vld !== 1'b0 || bus.sb_redirect_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got cnt=%0d vld=%b req=%b want 0 0 0",
               bus.sb_count, bus.sb_out_vld, bus.sb_redirect_req);
    end
    // Reset after a capture must discard it.
    stim[2] = mk(1'b0, 1'b0, 1'b1, 24'h5A5A5A);
    step();
    do_reset();
    checks++;
    if (bus.sb_count !== '0 || bus.sb_out_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_op got cnt=%0d vld=%b want 0 0", bus.sb_count, bus.sb_out_vld);
    end
  endtask

  task automatic test_capture();
    do_reset();
    stim[1] = mk(1'b0, 1'b0, 1'b1, 24'h111111);
    stim[3] = mk(1'b0, 1'b0, 1'b1, 24'h333333);
    step();
    checks++;
    if (bus.link_out_3.deflect !== 1'b1 || bus.sb_out.deflect !== 1'b0 ||
        bus.sb_out.payload !== 24'h111111) begin
      errors++;
      $display("FAIL capture_fields got l3.defl=%b sb.defl=%b sb.pl=%h want 1 0 111111",
               bus.link_out_3.deflect, bus.sb_out.deflect, bus.sb_out.payload);
    end
  endtask

  task automatic test_golden();
    do_reset();
    stim[0] = mk(1'b1, 1'b0, 1'b1, 24'h0D0D0D);
    stim[2] = mk(1'b0, 1'b1, 1'b1, 24'h2C2C2C);
    step();
    checks++;
    if (bus.link_out_0.vld !== 1'b1 || bus.link_out_2.vld !== 1'b0 ||
        bus.sb_out.payload !== 24'h2C2C2C) begin
      errors++;
      $display("FAIL golden_skip got l0.vld=%b l2.vld=%b sb.pl=%h want 1 0 2c2c2c",
               bus.link_out_0.vld, bus.link_out_2.vld, bus.sb_out.payload);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int n = 0; n < DEPTH; n++) begin
      set_idle();
      stim[n % 4] = mk(1'b0, 1'b0, 1'b1, 24'(32'h100 + n));
      step();
    end
    set_idle();
    stim[2] = mk(1'b0, 1'b0, 1'b1, 24'h0000F5);
    step();
    checks++;
    if (bus.link_out_2.vld !== 1'b1 || bus.link_out_2.deflect !== 1'b1 || bus.sb_count !== 3'd4) begin
      errors++;
      $display("FAIL full_passthru got vld=%b defl=%b cnt=%0d want 1 1 4",
               bus.link_out_2.vld, bus.link_out_2.deflect, bus.sb_count);
    end
    set_idle();
    stim[1] = mk(1'b0, 1'b0, 1'b1, 24'h0000F6);
    rdy     = 1'b1;
    step();
    set_idle();
    rdy = 1'b1;
    repeat (DEPTH + 1) step();
  endtask

  task automatic test_redirect();
    do_reset();
    stim[3] = mk(1'b0, 1'b0, 1'b1, 24'h777777);
    step();
    set_idle();
    step();
    checks++;
    if (bus.sb_redirect_req !== 1'b0) begin
      errors++;
      $display("FAIL redirect_early got %b want 0", bus.sb_redirect_req);
    end
    step();
    checks++;
    if (bus.sb_redirect_req !== 1'b1) begin
      errors++;
      $display("FAIL redirect_rise got %b want 1", bus.sb_redirect_req);
    end
    rdy = 1'b1;
    step();
    checks++;
    if (bus.sb_redirect_req !== 1'b0 || bus.sb_count !== '0) begin
      errors++;
      $display("FAIL redirect_clear got req=%b cnt=%0d want 0 0", bus.sb_redirect_req, bus.sb_count);
    end
  endtask

  task automatic test_stats();
    logic [15:0] exp_buf;
    logic [15:0] exp_red;
    do_reset();
    for (int n = 0; n < 5; n++) begin
      set_idle();
      stim[0] = mk(1'b0, 1'b0, 1'b1, 24'(32'h500 + n));
      rdy     = (n == 4);
      step();
    end
`ifdef MINBD_SB_STATS_EN
    exp_buf = 16'd5;
    exp_red = 16'd1;
`else
    exp_buf = 16'd0;
    exp_red = 16'd0;
`endif
    checks++;
    if (bus.sb_stat_buffered !== exp_buf) begin
      errors++;
      $display("FAIL stat_buffered got %0d want %0d", bus.sb_stat_buffered, exp_buf);
    end
    checks++;
    if (bus.sb_stat_redirect !== exp_red) begin
      errors++;
      $display("FAIL stat_redirect got %0d want %0d", bus.sb_stat_redirect, exp_red);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_buf;
    logic [15:0] exp_red;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) stim[i] = rnd_flit();
      rdy = ($urandom_range(0, 9) < 4);
      step();
    end
`ifdef MINBD_SB_STATS_EN
    exp_buf = 16'(pushes_m);
    exp_red = 16'(redirs_m);
`else
    exp_buf = 16'd0;
    exp_red = 16'd0;
`endif
    checks++;
    if (bus.sb_stat_buffered !== exp_buf || bus.sb_stat_redirect !== exp_red) begin
      errors++;
      $display("FAIL random_stats got %0d/%0d want %0d/%0d", bus.sb_stat_buffered,
               bus.sb_stat_redirect, exp_buf, exp_red);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    apply_inputs();
    clear_model();
    #1;
    test_reset();
    test_capture();
    test_golden();
    test_full();
    test_redirect();
    test_stats();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/minbd_side_buffer.md
Name: minbd_side_buffer

Overview:
- Sits directly downstream of the 4-port permutation network in the MinBD router.
- Registers the four permuted flits onto the output link registers.
- Removes at most one deflected, non-golden flit per cycle into a small side-buffer FIFO.
- Offers the buffered flit upstream for re-injection, and raises a redirection request when re-injection starves.

Parameters:
- SB_DEPTH, 4, side-buffer FIFO entries (power of 2, >=2).
- REDIR_THRESH, 2, consecutive stalled cycles with a waiting head before redirection is requested (1..15).

Ports:
- clk  input  1  router clock.
- rst_n  input  1  synchronous active-low reset.
- pn_in_0..pn_in_3  input  flit_int_t  permutation-network outputs dout_0..dout_3.
- link_out_0..link_out_3  output  flit_int_t  registered flits to output links.
- sb_out  output  flit_int_t  side-buffer head flit for re-injection.
- sb_out_vld  output  1  head valid (FIFO non-empty).
- sb_out_rdy  input  1  upstream redirection/injection mux accepts head.
- sb_redirect_req  output  1  starvation: upstream must force-redirect a link flit to free a slot for the head.
- sb_count  output  $clog2(SB_DEPTH)+1  occupancy.
- sb_stat_buffered  output  16  stats: flits captured (optional feature).
- sb_stat_redirect  output  16  stats: redirect assertions (optional feature).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All link_out_* vld=0, full flit zeroed.
  - sb_out_vld=0; sb_count=0; rd/wr pointers=0.
  - Stall counter=0; FSM=EMPTY; sb_redirect_req=0.
  - Reset mid-operation discards buffered flits; no pop is signalled.
- Candidate: lowest index i with pn_in_i.vld && pn_in_i.deflect && !pn_in_i.golden.
  - Golden flits are never captured.
  - Silver status is ignored.
- Push condition: candidate exists && (sb_count<SB_DEPTH || pop this cycle).
- Pop: sb_out_vld && sb_out_rdy.
- Full FIFO with simultaneous push and pop: both occur, count unchanged.
- On push:
  - Candidate is written with deflect=0.
  - The corresponding link_out_i next cycle has vld=0; all other fields are don't-care.
- Pass-through: every other pn_in_j is copied to link_out_j on the next edge, unmodified (1-cycle latency).
- No candidate, or full without pop: all four flits pass through unchanged, still marked deflect.
- sb_out is combinational from the FIFO head; contents are stable while sb_out_vld && !sb_out_rdy.
- Pointers wrap modulo SB_DEPTH; count = pushes - pops.
- FSM, registered:
  - EMPTY: sb_count==0. Push -> WAIT.
  - WAIT: head waiting.
    - Pop leaving empty and no push -> EMPTY.
    - Otherwise, stall counter increments on each cycle with vld && !rdy and clears on pop.
    - Counter reaching REDIR_THRESH -> REDIRECT.
  - REDIRECT: sb_redirect_req=1.
    - Pop -> WAIT (or EMPTY if it empties the FIFO); counter cleared; sb_redirect_req deasserts the cycle after the pop.
- Stall counter is 4 bits, saturating.
- sb_redirect_req is a registered output asserted only in REDIRECT.

Optional Feature:
- Macro: MINBD_SB_STATS_EN.
- Defined:
  - sb_stat_buffered increments on every push.
  - sb_stat_redirect increments on each WAIT->REDIRECT transition.
  - Both are 16-bit, saturating at 16'hFFFF, and reset to 0.
- Undefined: both ports are tied to 0 and no counter logic is present.

Test Plan:
- Reset: rst_n=0 for 2 cycles with valid inputs applied -> all link_out vld=0, sb_count=0, sb_out_vld=0, sb_redirect_req=0.
- pn_in_1 and pn_in_3 both vld&deflect, non-golden, FIFO empty, sb_out_rdy=0 -> next cycle link_out_1.vld=0, link_out_3 passes with deflect=1, sb_count=1, sb_out = pn_in_1's flit with deflect=0.
- Golden deflected flit on pn_in_0 plus silver deflected flit on pn_in_2 -> pn_in_2 captured, link_out_0 passes.
- Fill FIFO to 4 with sb_out_rdy=0, then a deflected flit arrives -> passes through, count stays 4. Repeat with sb_out_rdy=1 -> push and pop same cycle, count stays 4, FIFO order preserved.
- Hold sb_out_rdy=0 with FIFO non-empty -> sb_redirect_req rises after exactly 2 stalled cycles. Assert rdy for 1 cycle -> pop occurs, sb_redirect_req=0 next cycle.
- With MINBD_SB_STATS_EN defined: 5 pushes and 1 redirect -> sb_stat_buffered=5, sb_stat_redirect=1. Undefined: both read 0.
